// File: rtl/adder129_rr_arbiter_if.sv
// Bundle between the shared-adder arbiter, its requesters,
// the adder instance and the response consumer.
interface adder129_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic                   en;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*129-1:0]    req_a;
  logic [NREQ*129-1:0]    req_b;
  logic [128:0]           add_ain;
  logic [128:0]           add_bin;
  logic [129:0]           add_sum;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [129:0]           rsp_sum;
  logic                   idle;
  logic [31:0]            issue_cnt;

  modport master (
    output en,
    output req_valid,
    output req_a,
    output req_b,
    output add_sum,
    input  req_ready,
    input  add_ain,
    input  add_bin,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_sum,
    input  idle,
    input  issue_cnt
  );

  modport slave (
    input  en,
    input  req_valid,
    input  req_a,
    input  req_b,
    input  add_sum,
    output req_ready,
    output add_ain,
    output add_bin,
    output rsp_valid,
    output rsp_id,
    output rsp_sum,
    output idle,
    output issue_cnt
  );
endinterface

// File: rtl/adder129_rr_arbiter.sv
// Round-robin share of one pipelined 129-bit adder between NREQ
// requesters; results come back tagged with the requester id.
module adder129_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int LAT  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  adder129_rr_arbiter_if.slave bus
);
  localparam int W = 129;

  logic [IDW-1:0]          ptr_q;
  logic [IDW-1:0]          ptr_d;
  logic [31:0]             cnt_q;
  logic [31:0]             cnt_d;
  logic [LAT-1:0]          tag_v_q;
  logic [LAT-1:0]          tag_v_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q;
  logic [LAT-1:0][IDW-1:0] tag_id_d;
  logic                    rsp_valid_q;
  logic                    rsp_valid_d;
  logic [IDW-1:0]          rsp_id_q;
  logic [IDW-1:0]          rsp_id_d;
  logic [W:0]              rsp_sum_q;
  logic [W:0]              rsp_sum_d;

  logic [NREQ-1:0]         gnt;
  logic                    gnt_any;
  logic [IDW-1:0]          gnt_id;
  logic [W-1:0]            ain;
  logic [W-1:0]            bin;

  // Scan starts one past the last winner, so the last winner goes last.
  always_comb begin : arb
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (bus.en && !gnt_any &&
          bus.req_valid[idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IDW-1:0];
        gnt[idx[IDW-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin : mux
    ain = '0;
    bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      ain = ain | ({W{gnt[i]}} & bus.req_a[i*W +: W]);
      bin = bin | ({W{gnt[i]}} & bus.req_b[i*W +: W]);
    end
  end

  always_comb begin : nxt
    ptr_d       = gnt_any ? gnt_id : ptr_q;
    cnt_d       = cnt_q + {31'd0, gnt_any};
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = gnt_any;
    tag_id_d[0] = gnt_id;
    for (int s = 1; s < LAT; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
    // Adder output lines up with the oldest tag stage.
    rsp_valid_d = tag_v_q[LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    if (tag_v_q[LAT-1]) begin
      rsp_id_d  = tag_id_q[LAT-1];
      rsp_sum_d = bus.add_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.add_ain   = ain;
  assign bus.add_bin   = bin;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.issue_cnt = cnt_q;
  assign bus.idle      = ~|tag_v_q & ~rsp_valid_q;
endmodule

// File: tb/tb_adder129_rr_arbiter.sv
// Random and directed checks of the shared-adder arbiter against
// a queue-based model of grants and tagged responses.
module tb_adder129_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 1;
  localparam int W   = 129;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder129_rr_arbiter_if #(.NREQ(N), .IDW(IDW)) bus ();

  adder129_rr_arbiter #(
    .NREQ(N),
    .IDW (IDW),
    .LAT (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural adder: LAT-stage pipe of full sums.
  logic [W:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, bus.add_ain} + {1'b0, bus.add_bin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.add_sum = apipe[LAT-1];

  typedef struct {
    int         due;
    int         id;
    logic [W:0] sum;
  } exp_t;

  exp_t        q[$];
  int          mptr;
  int unsigned mcnt;
  logic [W:0]  last_sum;
  int          last_id;
  int          now;
  int          n_rsp;
  int          n_cmp;
  int          n_err;

  bit             pend_v [N];
  logic [W-1:0]   pend_a [N];
  logic [W-1:0]   pend_b [N];

  task automatic chk(input string tag, input logic [W:0] got,
                     input logic [W:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) r = '1;
    return r[W-1:0];
  endfunction

  function automatic int mgrant();
    if (!bus.en) return -1;
    for (int k = 1; k <= N; k++) begin
      if (pend_v[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    mptr     = N - 1;
    mcnt     = 0;
    last_sum = '0;
    last_id  = 0;
  endtask

  task automatic arm(input int i);
    if (!pend_v[i]) begin
      pend_v[i] = 1'b1;
      pend_a[i] = rnd_op();
      pend_b[i] = rnd_op();
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = pend_v[i];
      bus.req_a[i*W +: W]    = pend_a[i];
      bus.req_b[i*W +: W]    = pend_b[i];
    end
  endtask

  // One clock: check grant path, advance model, check registered outputs.
  task automatic cycle(output int g);
    logic [N-1:0] rdy;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    bit           ev;
    bit           eidle;
    exp_t         e;
    apply();
    #1;
    g   = mgrant();
    rdy = '0;
    ea  = '0;
    eb  = '0;
    if (g >= 0) begin
      rdy[g] = 1'b1;
      ea     = pend_a[g];
      eb     = pend_b[g];
    end
    chk("req_ready", {126'd0, bus.req_ready}, {126'd0, rdy});
    chk("add_ain", {1'b0, bus.add_ain}, {1'b0, ea});
    chk("add_bin", {1'b0, bus.add_bin}, {1'b0, eb});
    @(posedge clk);
    if (rst_n && g >= 0) begin
      e.due = now + LAT + 1;
      e.id  = g;
      e.sum = {1'b0, pend_a[g]} + {1'b0, pend_b[g]};
      q.push_back(e);
      mptr = g;
      mcnt++;
      pend_v[g] = 1'b0;
    end
    now++;
    @(negedge clk);
    eidle = (q.size() == 0);
    ev    = 1'b0;
    if (q.size() > 0 && q[0].due == now) begin
      ev       = 1'b1;
      last_id  = q[0].id;
      last_sum = q[0].sum;
      void'(q.pop_front());
      n_rsp++;
    end
    chk("rsp_valid", {129'd0, bus.rsp_valid}, {129'd0, ev});
    chk("rsp_id", {128'd0, bus.rsp_id}, 130'(last_id));
    chk("rsp_sum", bus.rsp_sum, last_sum);
    chk("issue_cnt", {98'd0, bus.issue_cnt}, {98'd0, mcnt});
    chk("idle", {129'd0, bus.idle}, {129'd0, eidle});
  endtask

  task automatic drain(input int n);
    int g;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    repeat (n) cycle(g);
  endtask

  initial begin
    int         g;
    int         base;
    logic [W:0] top;
    int         rr_exp [4];
    int         sp_exp [4];
    n_cmp = 0;
    n_err = 0;
    n_rsp = 0;
    now   = 0;
    rr_exp = '{0, 1, 2, 3};
    sp_exp = '{3, 1, 3, 1};
    top   = '0;
    top[W] = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    bus.en = 1'b1;
    apply();
    model_reset();
    @(negedge clk);

    // Reset with all requests up: grants visible, nothing registered.
    for (int i = 0; i < N; i++) arm(i);
    rst_n = 1'b0;
    repeat (3) cycle(g);
    rst_n = 1'b1;

    // Round-robin with everyone continuously valid.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) arm(i);
      cycle(g);
      chk("rr_order", 130'(g), 130'(rr_exp[k % 4]));
    end
    chk("rr_cnt", {98'd0, bus.issue_cnt}, 130'd8);
    drain(4);

    // Single request with carry out of bit 128.
    pend_v[2] = 1'b1;
    pend_a[2] = '1;
    pend_b[2] = 129'd1;
    cycle(g);
    chk("single_gnt", 130'(g), 130'd2);
    cycle(g);
    chk("single_v", {129'd0, bus.rsp_valid}, 130'd1);
    chk("single_id", {128'd0, bus.rsp_id}, 130'd2);
    chk("single_sum", bus.rsp_sum, top);
    drain(3);

    // Sparse fairness: park ptr on 1, then 1 and 3 compete.
    arm(1);
    cycle(g);
    for (int k = 0; k < 4; k++) begin
      arm(1);
      arm(3);
      cycle(g);
      chk("sparse", 130'(g), 130'(sp_exp[k]));
    end
    drain(4);

    // Drop en after two grants.
    base = n_rsp;
    for (int i = 0; i < N; i++) arm(i);
    cycle(g);
    cycle(g);
    bus.en = 1'b0;
    repeat (5) cycle(g);
    chk("en_rsp", 130'(n_rsp - base), 130'd2);
    chk("en_idle", {129'd0, bus.idle}, 130'd1);
    bus.en = 1'b1;
    drain(5);

    // Reset while an op is in flight.
    base = n_rsp;
    arm(0);
    cycle(g);
    rst_n = 1'b0;
    model_reset();
    repeat (2) cycle(g);
    rst_n = 1'b1;
    repeat (4) cycle(g);
    chk("rst_rsp", 130'(n_rsp - base), 130'd0);
    chk("rst_cnt", {98'd0, bus.issue_cnt}, 130'd0);

    // Random traffic with occasional en drops.
    for (int k = 0; k < 600; k++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) arm(i);
      end
      cycle(g);
    end
    bus.en = 1'b1;
    drain(LAT + 4);
    chk("end_idle", {129'd0, bus.idle}, 130'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
